// File: rtl/logic_pipe.sv
// One-stage pipelined bitwise logic unit with valid/ready handshake and an XOR-accumulate checksum mode.
// Optional even-parity output on the result is enabled by defining LOGIC_PIPE_PARITY_EN.
module logic_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             first,
   input  logic             last,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic [CNT_W-1:0] beats
`ifdef LOGIC_PIPE_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam int unsigned OP_W = 3;
   localparam logic [OP_W-1:0] OP_AND  = 3'b000;
   localparam logic [OP_W-1:0] OP_OR   = 3'b001;
   localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
   localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
   localparam logic [OP_W-1:0] OP_XNOR = 3'b100;
   localparam logic [OP_W-1:0] OP_ANDN = 3'b101;
   localparam logic [OP_W-1:0] OP_ACC  = 3'b110;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [WIDTH-1:0] res_nxt;
   logic [CNT_W-1:0] beats_nxt;
   logic             valid_nxt;

   logic             accept;
   logic             consume;
   logic             restart;
   logic [WIDTH-1:0] acc_base;
   logic [WIDTH-1:0] acc_fold;
   logic [CNT_W-1:0] cnt_inc;
   logic [WIDTH-1:0] logic_res;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid && out_ready;

   // An accumulate beat starts fresh when no accumulation is open or first is set.
   assign restart  = (state == IDLE) || first;
   assign acc_base = restart ? '0 : acc;
   assign acc_fold = acc_base ^ A ^ B;
   assign cnt_inc  = restart ? CNT_ONE
                   : ((count == CNT_MAX) ? count : count + CNT_ONE);

   always_comb begin
      logic_res = '0;
      case (op)
         OP_AND:  logic_res = A & B;
         OP_OR:   logic_res = A | B;
         OP_XOR:  logic_res = A ^ B;
         OP_NOR:  logic_res = ~(A | B);
         OP_XNOR: logic_res = ~(A ^ B);
         OP_ANDN: logic_res = A & ~B;
         default: logic_res = '0;
      endcase
   end

   // Next-state and next-output decode; plain ops leave the accumulator untouched.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      count_nxt = count;
      res_nxt   = res;
      beats_nxt = beats;
      valid_nxt = consume ? 1'b0 : out_valid;
      if (accept) begin
         if (op == OP_ACC) begin
            if (last) begin
               res_nxt   = acc_fold;
               beats_nxt = cnt_inc;
               valid_nxt = 1'b1;
               acc_nxt   = '0;
               count_nxt = '0;
               state_nxt = IDLE;
            end else begin
               acc_nxt   = acc_fold;
               count_nxt = cnt_inc;
               state_nxt = ACCUM;
            end
         end else begin
            res_nxt   = logic_res;
            beats_nxt = CNT_ONE;
            valid_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         res       <= '0;
         beats     <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         count     <= count_nxt;
         res       <= res_nxt;
         beats     <= beats_nxt;
         out_valid <= valid_nxt;
      end
   end

`ifdef LOGIC_PIPE_PARITY_EN
   // Parity follows res, so it holds under backpressure along with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity <= 1'b0;
      end else begin
         parity <= ^res_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// Directed bench for logic_pipe with a transaction-level reference model checked every cycle.
module tb_logic_pipe;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 2;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic             first;
   logic             last;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic [CNT_W-1:0] beats;
`ifdef LOGIC_PIPE_PARITY_EN
   logic             parity;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .op(op),
      .first(first),
      .last(last),
      .A(a),
      .B(b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .res(res),
      .beats(beats)
`ifdef LOGIC_PIPE_PARITY_EN
      ,
      .parity(parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endfunction

   // Reference model: holds the expected output word and an unbounded beat tally.
   bit          m_valid;
   logic [31:0] m_res;
   int          m_beats;
   bit          m_open;
   logic [31:0] m_acc;
   int          m_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 0; m_res = 0; m_beats = 0; m_open = 0; m_acc = 0; m_cnt = 0;
      end else begin
         bit ready;
         ready = !m_valid || out_ready;
         if (m_valid && out_ready) m_valid = 0;
         if (in_valid && ready) begin
            if (op == 3'd6) begin
               if (first || !m_open) begin
                  m_acc = 0;
                  m_cnt = 0;
               end
               m_acc = m_acc ^ a ^ b;
               m_cnt++;
               if (last) begin
                  m_res   = m_acc;
                  m_beats = (m_cnt > CNT_SAT) ? CNT_SAT : m_cnt;
                  m_valid = 1;
                  m_open  = 0;
                  m_acc   = 0;
                  m_cnt   = 0;
               end else begin
                  m_open = 1;
               end
            end else begin
               case (op)
                  3'd0: m_res = a & b;
                  3'd1: m_res = a | b;
                  3'd2: m_res = a ^ b;
                  3'd3: m_res = ~(a | b);
                  3'd4: m_res = ~(a ^ b);
                  3'd5: m_res = a & ~b;
                  default: m_res = 0;
               endcase
               m_beats = 1;
               m_valid = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cyc_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
         chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
         chk("cyc_res", res, m_res);
         chk("cyc_beats", 32'(beats), 32'(m_beats));
`ifdef LOGIC_PIPE_PARITY_EN
         chk("cyc_parity", 32'(parity), 32'(^m_res));
`endif
      end
   end

   task automatic beat(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic f, input logic l);
      in_valid = 1'b1; op = o; a = av; b = bv; first = f; last = l;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_tab [6];
      exp_tab[0] = 32'h00F0_1234; exp_tab[1] = 32'hFFF0_FFFF; exp_tab[2] = 32'hFF00_EDCB;
      exp_tab[3] = 32'h000F_0000; exp_tab[4] = 32'h00FF_1234; exp_tab[5] = 32'hF000_0000;

      rst = 1'b1; in_valid = 0; op = 0; first = 0; last = 0; a = 0; b = 0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_res", res, 32'h0);
      chk("reset_beats", 32'(beats), 32'h0);
      @(negedge clk); #1;
      rst = 1'b0;
      chk("reset_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #1;

      // Plain ops, back to back
      for (int i = 0; i < 6; i++) begin
         beat(3'(i), 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0);
         chk($sformatf("op%0d_res", i), res, exp_tab[i]);
         chk($sformatf("op%0d_beats", i), 32'(beats), 32'h1);
      end
      beat(3'd7, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 1'b0);
      chk("reserved_res", res, 32'h0);
      chk("reserved_beats", 32'(beats), 32'h1);
      idle(1);
      chk("drained_valid", 32'(out_valid), 32'h0);

      // Backpressure: XOR result held while the next beat waits
      beat(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0);
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'd1; a = 32'h1; b = 32'h2;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_in_ready", 32'(in_ready), 32'h0);
         chk("bp_res", res, 32'hFF00_EDCB);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_release_res", res, 32'h3);
      chk("bp_release_valid", 32'(out_valid), 32'h1);
      idle(2);

      // Three-beat accumulation
      beat(3'd6, 32'h1, 32'h2, 1'b1, 1'b0);
      chk("acc1_no_valid", 32'(out_valid), 32'h0);
      beat(3'd6, 32'h4, 32'h8, 1'b0, 1'b0);
      chk("acc2_no_valid", 32'(out_valid), 32'h0);
      beat(3'd6, 32'h10, 32'h20, 1'b0, 1'b1);
      chk("acc3_res", res, 32'h3F);
      chk("acc3_beats", 32'(beats), 32'h3);
      idle(1);

      // AND interleaved into an open accumulation
      beat(3'd6, 32'h1, 32'h2, 1'b1, 1'b0);
      beat(3'd0, 32'hFFFF, 32'h0F0F, 1'b0, 1'b0);
      chk("ilv_and_res", res, 32'h0F0F);
      beat(3'd6, 32'h4, 32'h8, 1'b0, 1'b0);
      beat(3'd6, 32'h10, 32'h20, 1'b0, 1'b1);
      chk("ilv_acc_res", res, 32'h3F);
      chk("ilv_acc_beats", 32'(beats), 32'h3);
      idle(1);

      // Non-last accumulate beat stalls behind an unconsumed result
      beat(3'd1, 32'hA0, 32'h05, 1'b0, 1'b0);
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'd6; a = 32'h100; b = 32'h0; first = 1'b1; last = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      beat(3'd6, 32'h0, 32'h1, 1'b0, 1'b1);
      chk("stall_acc_res", res, 32'h101);
      chk("stall_acc_beats", 32'(beats), 32'h2);
      idle(1);

      // Reset mid-accumulation with a pending output
      beat(3'd6, 32'h1, 32'h2, 1'b1, 1'b0);
      beat(3'd6, 32'h4, 32'h8, 1'b0, 1'b0);
      beat(3'd1, 32'hAA, 32'h55, 1'b0, 1'b0);
      out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_res", res, 32'h0);
      chk("rst_beats", 32'(beats), 32'h0);
      @(negedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      beat(3'd6, 32'h5, 32'h0, 1'b0, 1'b1);
      chk("post_rst_res", res, 32'h5);
      chk("post_rst_beats", 32'(beats), 32'h1);
      idle(1);

      // Six beats saturate the 2-bit counter
      for (int i = 0; i < 6; i++) begin
         beat(3'd6, 32'(1) << i, 32'(1) << (i + 8), 1'(i == 0), 1'(i == 5));
      end
      chk("sat_res", res, 32'h3F3F);
      chk("sat_beats", 32'(beats), 32'h3);
      idle(1);

      beat(3'd2, 32'h1, 32'h0, 1'b0, 1'b0);
      chk("par1_res", res, 32'h1);
`ifdef LOGIC_PIPE_PARITY_EN
      chk("par1_parity", 32'(parity), 32'h1);
`endif
      beat(3'd2, 32'h3, 32'h0, 1'b0, 1'b0);
      chk("par3_res", res, 32'h3);
`ifdef LOGIC_PIPE_PARITY_EN
      chk("par3_parity", 32'(parity), 32'h0);
`endif
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/logic_pipe.md
Name: logic_pipe

Overview:
- Parametrised, registered successor to the plain 32-bit XOR: a one-stage pipelined bitwise logic unit with a valid/ready handshake on both sides.
- Adds a multi-beat XOR-accumulate mode that folds a stream of operands into one checksum word.
- Sits between the register file and the writeback or checksum path of the CPU datapath; single clock domain.

Parameters:
- WIDTH, 32, operand and result width in bits (>=1).
- CNT_W, 8, width of the accumulate beat counter; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- op  input  3  operation select (see Behaviour).
- first  input  1  ACC_XOR only: start a new accumulation.
- last  input  1  ACC_XOR only: final beat, emit result.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  downstream accepts result.
- res  output  WIDTH  registered result.
- beats  output  CNT_W  number of beats folded into res (1 for non-accumulate ops).

Behaviour:
- Reset (async, rst=1): out_valid=0, res=0, beats=0, acc=0, count=0, state=IDLE. in_ready=1 once rst deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - A beat is accepted when in_valid && in_ready.
  - An output is consumed when out_valid && out_ready.
  - res and beats are held stable while out_valid && !out_ready.
- Latency: an accepted result beat appears on res with out_valid=1 on the next rising edge. Back-to-back throughput is 1 beat per cycle while out_ready=1.
- op encoding:
  - 000 AND, A&B.
  - 001 OR, A|B.
  - 010 XOR, A^B.
  - 011 NOR, ~(A|B).
  - 100 XNOR, ~(A^B).
  - 101 ANDN, A&~B.
  - 110 ACC_XOR.
  - 111 reserved: res=0, beats=1, treated as a result beat.
- Non-accumulate ops: the accepted beat loads res and sets beats=1, out_valid=1. acc, count and state are untouched, so they may interleave with an open accumulation.
- ACC_XOR state machine, states IDLE and ACCUM. Let base = (state==IDLE || first) ? 0 : acc, and nxt = base ^ A ^ B.
  - Accepted beat with last=0: acc<=nxt; count<=(base==0 from IDLE/first ? 1 : count+1, saturating); state<=ACCUM; no output produced, out_valid unchanged.
  - Accepted beat with last=1: res<=nxt; beats<=final count including this beat; out_valid<=1; acc<=0; count<=0; state<=IDLE.
  - first=1 while in ACCUM discards the open accumulation and restarts.
  - first=1 with last=1 is a single-beat checksum: res=A^B, beats=1.
  - ACC_XOR in IDLE without first behaves as if first=1.
- Non-last ACC beats still require in_ready, so they stall behind an unconsumed result.
- Counter saturates at all-ones and never wraps; res is still correct.
- Output consumed with no new result accepted in the same cycle: out_valid<=0, res holds its last value.
- Consume and load in the same cycle: new result loaded, out_valid stays 1.
- rst asserted mid-accumulation or with a pending output: everything clears immediately; the partial accumulation is lost.

Optional Feature:
- Macro LOGIC_PIPE_PARITY_EN.
- Defined: adds output port parity (1 bit), registered with res, equal to ^res of the loaded result (even parity bit). Reset value 0; held with res under backpressure.
- Undefined: port absent, no parity logic; all other behaviour identical.

Test Plan:
- Reset then ops 000..101 with A=32'hF0F0_1234, B=32'h0FF0_FFFF, out_ready=1 -> results each one cycle later:
  - AND 32'h00F0_1234, OR 32'hFFF0_FFFF, XOR 32'hFF00_EDCB.
  - NOR 32'h000F_0000, XNOR 32'h00FF_1234, ANDN 32'hF000_0000.
  - beats=1 for each.
- Backpressure: out_ready=0 after one XOR result -> in_ready=0 and res stable for 5 cycles. Release -> next queued beat loads on the following edge, with no loss or duplication.
- ACC_XOR three beats (first on beat 1, last on beat 3): A/B = 1/2, 4/8, 16/32 -> single output res=32'h3F, beats=3; no out_valid on beats 1-2.
- Interleave: AND beat between ACC beats 1 and 2 -> AND result emitted; accumulation result unchanged at 32'h3F, beats=3.
- rst pulse after ACC beat 2 -> outputs 0 immediately. A new accumulation without first, A=5, B=0, last=1 -> res=5, beats=1.
- With CNT_W=2, 6-beat accumulation -> beats saturates at 3; res equals the XOR of all 12 operands. With LOGIC_PIPE_PARITY_EN: parity=1 for res=32'h1, and 0 for res=32'h3.
